// File: rtl/mod_seq_ctrl.sv
// Sequenced remainder engine: restoring shift-subtract over DATAWIDTH cycles with valid/ready on both sides.
// Define MOD_QUOT_OUT_EN to add the quot output port (quotient collected in the dividend shift register).
module mod_seq_ctrl #(
   parameter int DATAWIDTH = 8
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATAWIDTH-1:0] rem,
   output logic                 div_zero,
`ifdef MOD_QUOT_OUT_EN
   output logic [DATAWIDTH-1:0] quot,
`endif
   output logic                 busy
);

   localparam int CW = $clog2(DATAWIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(DATAWIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t               state_q, state_d;
   logic [DATAWIDTH-1:0] dvd_q, dvd_d;
   logic [DATAWIDTH-1:0] div_q, div_d;
   logic [DATAWIDTH-1:0] p_q, p_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [DATAWIDTH-1:0] rem_q, rem_d;
   logic                 div_zero_q, div_zero_d;
`ifdef MOD_QUOT_OUT_EN
   logic [DATAWIDTH-1:0] quot_q, quot_d;
`endif

   logic [DATAWIDTH:0]   p_shift;
   logic [DATAWIDTH-1:0] p_sub;
   logic [DATAWIDTH-1:0] p_next;
   logic                 q_bit;

   // The shifted remainder carries one extra bit; after a restoring step the
   // result is always below the divisor, so only DATAWIDTH bits are kept.
   always_comb begin
      p_shift = {p_q, dvd_q[DATAWIDTH-1]};
      q_bit   = p_shift[DATAWIDTH] || (p_shift[DATAWIDTH-1:0] >= div_q);
      p_sub   = p_shift[DATAWIDTH-1:0] - div_q;
      p_next  = q_bit ? p_sub : p_shift[DATAWIDTH-1:0];
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q    <= IDLE;
         dvd_q      <= '0;
         div_q      <= '0;
         p_q        <= '0;
         cnt_q      <= '0;
         rem_q      <= '0;
         div_zero_q <= 1'b0;
`ifdef MOD_QUOT_OUT_EN
         quot_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         dvd_q      <= dvd_d;
         div_q      <= div_d;
         p_q        <= p_d;
         cnt_q      <= cnt_d;
         rem_q      <= rem_d;
         div_zero_q <= div_zero_d;
`ifdef MOD_QUOT_OUT_EN
         quot_q     <= quot_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = (b == '0) ? DONE : CALC;
         CALC:    if (cnt_q == '0) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      dvd_d      = dvd_q;
      div_d      = div_q;
      p_d        = p_q;
      cnt_d      = cnt_q;
      rem_d      = rem_q;
      div_zero_d = div_zero_q;
`ifdef MOD_QUOT_OUT_EN
      quot_d     = quot_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               dvd_d = a;
               div_d = b;
               p_d   = '0;
               if (b == '0) begin
                  rem_d      = a;
                  div_zero_d = 1'b1;
`ifdef MOD_QUOT_OUT_EN
                  quot_d     = '1;
`endif
               end else begin
                  cnt_d      = CNT_LAST;
                  div_zero_d = 1'b0;
               end
            end
         end
         CALC: begin
            p_d = p_next;
`ifdef MOD_QUOT_OUT_EN
            dvd_d = {dvd_q[DATAWIDTH-2:0], q_bit};
`else
            dvd_d = {dvd_q[DATAWIDTH-2:0], 1'b0};
`endif
            if (cnt_q == '0) begin
               rem_d  = p_next;
`ifdef MOD_QUOT_OUT_EN
               quot_d = {dvd_q[DATAWIDTH-2:0], q_bit};
`endif
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state_q)
         IDLE:    in_ready = 1'b1;
         CALC:    busy = 1'b1;
         DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: ;
      endcase
      rem      = rem_q;
      div_zero = div_zero_q;
`ifdef MOD_QUOT_OUT_EN
      quot     = quot_q;
`endif
   end

endmodule
